// File: rtl/instr_fetch.sv
// instr_fetch: MIPS PC register and req/ack instruction fetch stage
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        instr_valid,
  input  logic        instr_accept,
  input  logic        pcsrc,
  input  logic        jump,
  input  logic [31:0] branch_imm,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] retired_count
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t state, state_n;
  logic [31:0] pc_n, instr_n, count_n, next_pc;
  assign imem_req = state == FETCH && !reset;
  assign imem_addr = pc;
  assign opcode = instr[31:26];
  assign func = instr[5:0];
  assign pc_plus4 = pc + 32'd4;
  assign instr_valid = state == HOLD;
  // jump beats a taken branch; the jump index comes from the latched word
  assign next_pc = jump ? {pc_plus4[31:28], instr[25:0], 2'b00} :
                   pcsrc ? pc_plus4 + (branch_imm << 2) : pc_plus4;
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = instr;
    count_n = retired_count;
    if (state == FETCH && imem_ack) begin
      state_n = HOLD;
      instr_n = imem_rdata;
    end
    if (state == HOLD && instr_accept) begin
      state_n = FETCH;
      pc_n = next_pc;
      count_n = retired_count + 32'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      instr <= '0;
      retired_count <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      instr <= instr_n;
      retired_count <= count_n;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed vector table plus randomized run against a reference model
module tb_instr_fetch;
  logic clk = 1'b0;
  logic reset, imem_ack, instr_accept, pcsrc, jump;
  logic [31:0] imem_rdata, branch_imm;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pc_plus4, retired_count;
  logic [5:0] opcode, func;
  int checks = 0, errors = 0;
  localparam logic N = 1'b0, Y = 1'b1;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
    .func(func), .instr_valid(instr_valid), .instr_accept(instr_accept),
    .pcsrc(pcsrc), .jump(jump), .branch_imm(branch_imm), .pc(pc),
    .pc_plus4(pc_plus4), .retired_count(retired_count)
  );

  typedef struct {
    logic rst, ack;
    logic [31:0] rdata;
    logic acc, br, jmp;
    logic [31:0] imm;
    logic req;
    logic [31:0] pc;
    logic valid;
    logic [31:0] cnt, instr;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d, input logic c,
                       input logic b, input logic j, input logic [31:0] i);
    reset = r; imem_ack = a; imem_rdata = d; instr_accept = c; pcsrc = b; jump = j; branch_imm = i;
  endtask

  logic [31:0] m_pc, m_instr, m_cnt, prev_pc;
  logic m_hold;
  logic r, a, c, b, j;
  logic [31:0] d, i;

  initial begin
    // rst ack rdata acc br jmp imm | req(before edge) pc valid cnt instr (after edge)
    v.push_back('{Y, Y, 32'hDEAD_BEEF, N, N, N, 0, N, 0, N, 0, 0});
    v.push_back('{N, Y, 32'h2000_0000, N, N, N, 0, Y, 0, Y, 0, 32'h2000_0000});
    v.push_back('{N, Y, 32'hBAD0_0000, Y, N, N, 0, N, 4, N, 1, 32'h2000_0000});
    v.push_back('{N, Y, 32'h2000_0004, Y, N, N, 0, Y, 4, Y, 1, 32'h2000_0004});
    v.push_back('{N, N, 0, Y, N, N, 0, N, 8, N, 2, 32'h2000_0004});
    v.push_back('{N, Y, 32'h2000_0008, N, N, N, 0, Y, 8, Y, 2, 32'h2000_0008});
    v.push_back('{N, N, 0, Y, N, N, 0, N, 'hC, N, 3, 32'h2000_0008});
    v.push_back('{N, N, 0, N, N, N, 0, Y, 'hC, N, 3, 32'h2000_0008});
    v.push_back('{N, N, 0, Y, Y, Y, 0, Y, 'hC, N, 3, 32'h2000_0008});
    v.push_back('{N, N, 0, N, N, N, 0, Y, 'hC, N, 3, 32'h2000_0008});
    v.push_back('{N, Y, 32'h2000_000C, N, N, N, 0, Y, 'hC, Y, 3, 32'h2000_000C});
    v.push_back('{N, N, 0, Y, Y, N, 'hC, N, 'h40, N, 4, 32'h2000_000C});
    v.push_back('{N, Y, 32'h1000_0000, N, N, N, 0, Y, 'h40, Y, 4, 32'h1000_0000});
    v.push_back('{N, N, 0, Y, Y, N, 32'hFFFF_FFFE, N, 'h3C, N, 5, 32'h1000_0000});
    v.push_back('{N, Y, 0, N, N, N, 0, Y, 'h3C, Y, 5, 0});
    v.push_back('{N, N, 0, Y, N, N, 7, N, 'h40, N, 6, 0});
    v.push_back('{N, Y, 0, N, N, N, 0, Y, 'h40, Y, 6, 0});
    v.push_back('{N, N, 0, Y, Y, N, 5, N, 'h58, N, 7, 0});
    v.push_back('{N, Y, 0, N, N, N, 0, Y, 'h58, Y, 7, 0});
    v.push_back('{N, N, 0, Y, Y, N, 32'h1FFF_FFED, N, 32'h8000_0010, N, 8, 0});
    v.push_back('{N, Y, 32'h0800_0100, N, N, N, 0, Y, 32'h8000_0010, Y, 8, 32'h0800_0100});
    v.push_back('{N, N, 0, Y, Y, Y, 5, N, 32'h8000_0400, N, 9, 32'h0800_0100});
    v.push_back('{N, Y, 0, N, N, N, 0, Y, 32'h8000_0400, Y, 9, 0});
    v.push_back('{N, N, 0, Y, Y, N, 32'h1FFF_FEFE, N, 32'hFFFF_FFFC, N, 10, 0});
    v.push_back('{N, Y, 32'h0000_0123, N, N, N, 0, Y, 32'hFFFF_FFFC, Y, 10, 32'h0000_0123});
    v.push_back('{N, N, 0, Y, N, N, 0, N, 0, N, 11, 32'h0000_0123});
    v.push_back('{N, Y, 32'h1234_5678, N, N, N, 0, Y, 0, Y, 11, 32'h1234_5678});
    v.push_back('{N, N, 0, Y, N, N, 0, N, 4, N, 12, 32'h1234_5678});
    v.push_back('{N, Y, 32'h0ABC_DEF0, N, N, N, 0, Y, 4, Y, 12, 32'h0ABC_DEF0});
    v.push_back('{Y, N, 0, Y, Y, Y, 3, N, 0, N, 0, 0});
    v.push_back('{Y, Y, 32'hFFFF_FFFF, N, N, N, 0, N, 0, N, 0, 0});
    v.push_back('{N, N, 0, N, N, N, 0, Y, 0, N, 0, 0});
    prev_pc = 0;
    foreach (v[k]) begin
      drive(v[k].rst, v[k].ack, v[k].rdata, v[k].acc, v[k].br, v[k].jmp, v[k].imm);
      #1;
      chk($sformatf("vec%0d imem_req", k), 32'(imem_req), 32'(v[k].req));
      if (k > 0) chk($sformatf("vec%0d imem_addr", k), imem_addr, prev_pc);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pc", k), pc, v[k].pc);
      chk($sformatf("vec%0d pc_plus4", k), pc_plus4, v[k].pc + 32'd4);
      chk($sformatf("vec%0d instr_valid", k), 32'(instr_valid), 32'(v[k].valid));
      chk($sformatf("vec%0d retired_count", k), retired_count, v[k].cnt);
      chk($sformatf("vec%0d instr", k), instr, v[k].instr);
      chk($sformatf("vec%0d opcode", k), 32'(opcode), 32'(v[k].instr >> 26));
      prev_pc = v[k].pc;
    end
    m_pc = 0; m_instr = 0; m_cnt = 0; m_hold = 0;
    for (int n = 0; n < 600; n++) begin
      r = (n == 0) || ($urandom_range(0, 39) == 0);
      a = $urandom_range(0, 2) == 0;
      c = $urandom_range(0, 1) == 1;
      b = $urandom_range(0, 1) == 1;
      j = $urandom_range(0, 3) == 0;
      d = $urandom;
      i = $urandom_range(0, 1) ? $urandom : 32'($signed($urandom_range(0, 63)) - 32);
      drive(r, a, d, c, b, j, i);
      #1;
      if (n > 0) begin
        chk("rnd imem_req", 32'(imem_req), 32'(!m_hold && !r));
        chk("rnd imem_addr", imem_addr, m_pc);
        chk("rnd pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("rnd func", 32'(func), m_instr % 64);
      end
      if (r) begin
        m_pc = 0; m_instr = 0; m_cnt = 0; m_hold = 0;
      end else if (!m_hold) begin
        if (a) begin m_instr = d; m_hold = 1; end
      end else if (c) begin
        if (j) m_pc = ((m_pc + 4) & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
        else if (b) m_pc = m_pc + 4 + i * 4;
        else m_pc = m_pc + 4;
        m_cnt++;
        m_hold = 0;
      end
      @(posedge clk);
      #1;
      chk("rnd pc", pc, m_pc);
      chk("rnd instr_valid", 32'(instr_valid), 32'(m_hold));
      chk("rnd retired_count", retired_count, m_cnt);
      chk("rnd instr", instr, m_instr);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
